regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Sequential reader for the MIPS register file. On command, it walks a contiguous register range through one of the register file's asynchronous read ports.
- Each word read is streamed out as {address, data} on a valid/ready interface. Consumers are the debug/trace unit and context save.
- It snoops the register file's write port and flags the dump as stale if an already-captured register is overwritten.

Parameters:
- WIDTH, 32, data word width (must match register file)
- ADDR_WIDTH, 5, register address width (depth = 2**ADDR_WIDTH)
- SKIP_ZERO, 1, 1 = never emit register 0; 0 = emit it like any other

Ports:
- Clk  in  1  clock, positive edge
- ResetN  in  1  synchronous active-low reset
- Start  in  1  single-cycle command pulse, sampled only in IDLE
- StartReg  in  ADDR_WIDTH  first register of range, latched on accepted Start
- EndReg  in  ADDR_WIDTH  last register of range (inclusive), latched on accepted Start
- Abort  in  1  cancel dump in progress
- ReadRegister  out  ADDR_WIDTH  address to register file read port
- ReadData  in  WIDTH  asynchronous read data from register file
- RegWrite  in  1  snooped register file write enable
- WriteRegister  in  ADDR_WIDTH  snooped register file write address
- DumpData  out  WIDTH  streamed register contents
- DumpAddr  out  ADDR_WIDTH  register number of DumpData
- DumpValid  out  1  output word valid
- DumpReady  in  1  consumer accepts word when DumpValid&DumpReady at a rising edge
- DumpLast  out  1  current word is final word of range
- Busy  out  1  high in RUN
- Done  out  1  one-cycle pulse on normal completion
- RangeErr  out  1  one-cycle pulse when StartReg > EndReg
- Stale  out  1  sticky: a captured register was overwritten during the dump

Behaviour:
- Reset (ResetN=0 at edge): state=IDLE. All outputs 0: DumpData, DumpAddr, DumpValid, DumpLast, Busy, Done, RangeErr, Stale, ReadRegister. Takes priority over all inputs, including mid-dump; no Done is produced.
- States: IDLE, RUN, FIN.
  - FIN lasts exactly one cycle. It drives Done=1 (or RangeErr=1), then returns to IDLE.
- Accepted Start in IDLE: latch s=StartReg and e=EndReg. Clear Stale.
  - Set ptr=s. If SKIP_ZERO and s==0, set ptr=1.
  - If s>e: go to FIN with RangeErr=1, Done=0.
  - Else if ptr>e (only when the range is {0} with SKIP_ZERO): go to FIN with Done=1 and no words.
  - Else: go to RUN.
- Start is ignored outside IDLE.
- RUN:
  - ReadRegister=ptr (registered, so stable during the cycle).
  - The load condition is: ptr not exhausted AND (DumpValid==0 OR DumpReady==1).
  - On load, at the edge: DumpData<=ReadData, DumpAddr<=ptr, DumpLast<=(ptr==e), DumpValid<=1.
  - After loading, ptr increments. Once ptr has loaded e, it is exhausted.
  - On handshake with nothing to load: DumpValid<=0.
  - Handshake of the word with DumpLast=1 -> FIN, Done=1 next cycle, DumpValid<=0.
  - Throughput is 1 word/cycle while DumpReady=1.
  - Latency: Start sampled at edge t gives first DumpValid=1 after edge t+2.
- DumpData/DumpAddr/DumpLast hold stable while DumpValid=1 and DumpReady=0.
- Busy=1 exactly in RUN.
- Full range 0..31 with SKIP_ZERO=1 emits 31 words; with SKIP_ZERO=0 it emits 32 words. Register 0 data is always 0 from the register file.
- ptr must not wrap: it is ADDR_WIDTH+1 bits wide, or exhaustion is tracked by a flag. e=31 must terminate.
- Stale: set in RUN when RegWrite=1, WriteRegister!=0, s<=WriteRegister<=e, and either:
  - WriteRegister < ptr (already captured), or
  - WriteRegister==ptr AND a load occurs that cycle. The old value is captured, so the dump is stale.
  - Stale is held until the next accepted Start or reset. Writes in IDLE/FIN are ignored.
- Abort in RUN: next state IDLE. DumpValid, DumpLast and Busy go to 0. No Done. Stale is retained.
  - Abort in IDLE/FIN: no effect.
- Simultaneous Abort and final handshake: Abort wins, no Done.

Test Plan:
- Reg file preloaded with reg[n]=0x1000+n, SKIP_ZERO=1, Start with 0..31, DumpReady=1 -> 31 words on consecutive cycles, addr 1..31, data 0x1001..0x101F; DumpLast only on addr 31; Done pulse 1 cycle after last handshake; first DumpValid 2 cycles after Start.
- Range 4..7 with DumpReady toggling 1,0,0,1,0,1,1 -> exactly 4 words addr 4,5,6,7; data held stable across stalls; no duplicates or drops.
- StartReg=9, EndReg=3 -> RangeErr=1 for one cycle, DumpValid never 1, Done=0; StartReg=EndReg=0 with SKIP_ZERO=1 -> Done=1, no words.
- Range 2..10, write reg 3 (=0xDEAD) after reg 3 is captured -> Stale=1 and dump shows old 0x1003. Rerun with write to reg 8 before it is captured -> Stale=0, dump shows 0xDEAD.
- Abort at word addr 6 of range 2..10 -> DumpValid=0 next cycle, Busy=0, no Done. New Start is accepted afterwards and restarts at addr 2.
- ResetN=0 for one cycle mid-dump -> all outputs 0 next cycle, state IDLE; Start during reset is ignored.

Source files
------------

// File: rtl/regfile_dump.sv
// Walks a register range through an async regfile read port and streams {addr, data} words.
// Latency: Start sampled at edge t -> first DumpValid after edge t+2; then 1 word/cycle.
// Backpressure: valid/ready; the output word holds while DumpValid=1 and DumpReady=0.
module regfile_dump #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SKIP_ZERO  = 1
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartReg,
  input  logic [ADDR_WIDTH-1:0] EndReg,
  input  logic                  Abort,
  output logic [ADDR_WIDTH-1:0] ReadRegister,
  input  logic [WIDTH-1:0]      ReadData,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [WIDTH-1:0]      DumpData,
  output logic [ADDR_WIDTH-1:0] DumpAddr,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  DumpLast,
  output logic                  Busy,
  output logic                  Done,
  output logic                  RangeErr,
  output logic                  Stale
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] s_reg;
  logic [ADDR_WIDTH-1:0] e_reg;
  // One bit wider than an address so that e=all-ones still terminates.
  logic [ADDR_WIDTH:0]   ptr;
  logic [ADDR_WIDTH:0]   ptr_inc;
  logic [ADDR_WIDTH:0]   first_ptr;
  // Low for the first RUN cycle, while ReadRegister settles on the first address.
  logic                  armed;
  logic                  exhausted;
  logic                  hs;
  logic                  load;
  logic                  wr_in_range;
  logic                  hit;

  // First address of the walk, stepping over register 0 when it is never emitted.
  always_comb begin
    first_ptr = {1'b0, StartReg};
    if ((SKIP_ZERO != 0) && (StartReg == '0)) begin
      first_ptr = {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  assign ptr_inc     = ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign exhausted   = (ptr > {1'b0, e_reg});
  assign hs          = DumpValid & DumpReady;
  assign load        = (state == RUN) & ~Abort & armed & ~exhausted & (~DumpValid | DumpReady);
  assign wr_in_range = RegWrite & (WriteRegister != '0) &
                       (WriteRegister >= s_reg) & (WriteRegister <= e_reg);
  // A write lands on a captured register: either already loaded, or loaded this very edge with the old value.
  assign hit         = (state == RUN) & wr_in_range &
                       (({1'b0, WriteRegister} < ptr) | (({1'b0, WriteRegister} == ptr) & load));
  assign Busy        = (state == RUN);

  // Control FSM, address walk, output word register and sticky stale flag.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state        <= IDLE;
      s_reg        <= '0;
      e_reg        <= '0;
      ptr          <= '0;
      armed        <= 1'b0;
      ReadRegister <= '0;
      DumpData     <= '0;
      DumpAddr     <= '0;
      DumpValid    <= 1'b0;
      DumpLast     <= 1'b0;
      Done         <= 1'b0;
      RangeErr     <= 1'b0;
      Stale        <= 1'b0;
    end else begin
      Done     <= 1'b0;
      RangeErr <= 1'b0;
      if (hit) begin
        Stale <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (Start) begin
            s_reg <= StartReg;
            e_reg <= EndReg;
            Stale <= 1'b0;
            ptr   <= first_ptr;
            armed <= 1'b0;
            if (StartReg > EndReg) begin
              state    <= FIN;
              RangeErr <= 1'b1;
            end else if (first_ptr > {1'b0, EndReg}) begin
              state <= FIN;
              Done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            state     <= IDLE;
            DumpValid <= 1'b0;
            DumpLast  <= 1'b0;
          end else begin
            if (!armed) begin
              armed        <= 1'b1;
              ReadRegister <= ptr[ADDR_WIDTH-1:0];
            end
            if (hs && DumpLast) begin
              state     <= FIN;
              Done      <= 1'b1;
              DumpValid <= 1'b0;
              DumpLast  <= 1'b0;
            end else if (load) begin
              DumpData     <= ReadData;
              DumpAddr     <= ptr[ADDR_WIDTH-1:0];
              DumpLast     <= (ptr == {1'b0, e_reg});
              DumpValid    <= 1'b1;
              ptr          <= ptr_inc;
              ReadRegister <= ptr_inc[ADDR_WIDTH-1:0];
            end else if (hs) begin
              DumpValid <= 1'b0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
